// File: rtl/cve2_mac_sequencer.sv
// Multiply-accumulate sequencer: drives the shared ALU through MUL then ADD/SUB.
// Optional signed saturation of the add step with `define CVE2_MAC_SATURATE_EN.
package cve2_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_MUL = 4'd7,
        ALU_MAC = 4'd8
    } alu_op_e;
endpackage

module cve2_mac_sequencer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumAcc    = 4,
    localparam int unsigned AccIdxW  = (NumAcc > 1) ? $clog2(NumAcc) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  cve2_pkg::alu_op_e     alu_operator_i,
    input  logic                  mac_en_i,
    input  logic                  mac_sub_i,
    input  logic                  use_acc_i,
    input  logic [AccIdxW-1:0]    acc_sel_i,
    input  logic [DataWidth-1:0]  operand_a_i,
    input  logic [DataWidth-1:0]  operand_b_i,
    input  logic [DataWidth-1:0]  operand_c_i,
    input  logic                  flush_i,
    input  logic                  acc_clr_i,
    output cve2_pkg::alu_op_e     alu_operator_o,
    output logic [DataWidth-1:0]  alu_operand_a_o,
    output logic [DataWidth-1:0]  alu_operand_b_o,
    input  logic [DataWidth-1:0]  alu_result_i,
    input  logic                  mul_valid_i,
    output logic                  stall_o,
    output logic [DataWidth-1:0]  result_o,
    output logic                  result_valid_o
);
    import cve2_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] a_q, b_q, addend_q, product_q, result_q;
    logic                 sub_q, use_acc_q;
    logic [AccIdxW-1:0]   sel_q;
    logic [DataWidth-1:0] acc_q [NumAcc];
    logic [DataWidth-1:0] acc_rd;
    logic [DataWidth-1:0] add_result;
    logic                 start;

    assign start    = (state_q == IDLE) && (alu_operator_i == ALU_MAC) && mac_en_i && !flush_i;
    assign result_o = result_q;

    always_comb begin
        acc_rd = '0;
        for (int unsigned i = 0; i < NumAcc; i++) begin
            if (AccIdxW'(i) == acc_sel_i) acc_rd = acc_q[i];
        end
    end

`ifdef CVE2_MAC_SATURATE_EN
    // Subtraction flips the effective sign of the product before the overflow test.
    logic sign_a, sign_b, sign_r;
    always_comb begin
        sign_a     = addend_q[DataWidth-1];
        sign_b     = product_q[DataWidth-1] ^ sub_q;
        sign_r     = alu_result_i[DataWidth-1];
        add_result = alu_result_i;
        if ((sign_a == sign_b) && (sign_r != sign_a)) begin
            add_result = sign_a ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
        end
    end
`else
    assign add_result = alu_result_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL: begin
                if (flush_i)          state_d = IDLE;
                else if (mul_valid_i) state_d = ADD;
            end
            ADD:     state_d = flush_i ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_operator_o  = alu_operator_i;
        alu_operand_a_o = operand_a_i;
        alu_operand_b_o = operand_b_i;
        stall_o         = 1'b0;
        result_valid_o  = 1'b0;
        case (state_q)
            IDLE: stall_o = start;
            MUL: begin
                alu_operator_o  = ALU_MUL;
                alu_operand_a_o = a_q;
                alu_operand_b_o = b_q;
                stall_o         = 1'b1;
            end
            ADD: begin
                alu_operator_o  = sub_q ? ALU_SUB : ALU_ADD;
                alu_operand_a_o = addend_q;
                alu_operand_b_o = product_q;
                stall_o         = 1'b1;
            end
            DONE:    result_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q       <= '0;
            b_q       <= '0;
            addend_q  <= '0;
            product_q <= '0;
            result_q  <= '0;
            sub_q     <= 1'b0;
            use_acc_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            if (start) begin
                a_q       <= operand_a_i;
                b_q       <= operand_b_i;
                addend_q  <= use_acc_i ? acc_rd : operand_c_i;
                sub_q     <= mac_sub_i;
                use_acc_q <= use_acc_i;
                sel_q     <= acc_sel_i;
            end
            if ((state_q == MUL) && mul_valid_i && !flush_i) product_q <= alu_result_i;
            // Captured on the ADD->DONE edge so result_o only changes as DONE begins.
            if ((state_q == ADD) && !flush_i) result_q <= add_result;
        end
    end

    // A clear on the same index overrides the DONE write-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumAcc; i++) acc_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NumAcc; i++) begin
                if (acc_clr_i && (AccIdxW'(i) == acc_sel_i)) begin
                    acc_q[i] <= '0;
                end else if ((state_q == DONE) && use_acc_q && (AccIdxW'(i) == sel_q)) begin
                    acc_q[i] <= result_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_cve2_mac_sequencer.sv
// Self-checking bench for cve2_mac_sequencer; acts as the ALU and keeps a model of the accumulators.
module tb_cve2_mac_sequencer;
    import cve2_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    alu_op_e     alu_operator_i, alu_operator_o;
    logic        mac_en_i, mac_sub_i, use_acc_i, flush_i, acc_clr_i, mul_valid_i;
    logic [1:0]  acc_sel_i;
    logic [31:0] operand_a_i, operand_b_i, operand_c_i;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_result_i, result_o;
    logic        stall_o, result_valid_o;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_m [4];
    logic [31:0] last_res;

    always #5 clk_i = ~clk_i;

    cve2_mac_sequencer #(.DataWidth(32), .NumAcc(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_operator_i(alu_operator_i), .mac_en_i(mac_en_i), .mac_sub_i(mac_sub_i),
        .use_acc_i(use_acc_i), .acc_sel_i(acc_sel_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_c_i(operand_c_i),
        .flush_i(flush_i), .acc_clr_i(acc_clr_i),
        .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i),
        .mul_valid_i(mul_valid_i), .stall_o(stall_o),
        .result_o(result_o), .result_valid_o(result_valid_o)
    );

    // ALU stand-in
    always_comb begin
        case (alu_operator_o)
            ALU_MUL: alu_result_i = alu_operand_a_o * alu_operand_b_o;
            ALU_ADD: alu_result_i = alu_operand_a_o + alu_operand_b_o;
            ALU_SUB: alu_result_i = alu_operand_a_o - alu_operand_b_o;
            default: alu_result_i = '0;
        endcase
    end

    function automatic logic [31:0] mac_model(input logic [31:0] addend, input logic [31:0] prod,
                                              input logic sub);
        logic [31:0] w;
        w = sub ? addend - prod : addend + prod;
`ifdef CVE2_MAC_SATURATE_EN
        begin
            longint s;
            s = sub ? longint'($signed(addend)) - longint'($signed(prod))
                    : longint'($signed(addend)) + longint'($signed(prod));
            if (s > 64'sd2147483647)       w = 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) w = 32'h8000_0000;
        end
`endif
        return w;
    endfunction

    task automatic drive_idle();
        alu_operator_i = ALU_ADD;
        mac_en_i = 1'b0; mac_sub_i = 1'b0; use_acc_i = 1'b0; acc_sel_i = 2'd0;
        flush_i = 1'b0; acc_clr_i = 1'b0; mul_valid_i = 1'b0;
        operand_a_i = $urandom; operand_b_i = $urandom; operand_c_i = $urandom;
    endtask

    task automatic run_mac(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic ua, input logic sub,
                           input logic [1:0] sel, input int unsigned delay,
                           input bit clr_done, input bit req_done);
        logic [31:0] prod, addend, exp, got;
        bit          seen;
        int unsigned lat;
        prod   = a * b;
        addend = ua ? acc_m[sel] : c;
        exp    = mac_model(addend, prod, sub);
        exp_q.push_back(exp);
        if (clr_done) acc_m[sel] = '0;
        else if (ua)  acc_m[sel] = exp;

        @(posedge clk_i); #1;
        alu_operator_i = ALU_MAC; mac_en_i = 1'b1; mac_sub_i = sub; use_acc_i = ua;
        acc_sel_i = sel; operand_a_i = a; operand_b_i = b; operand_c_i = c;
        #1;
        total++;
        if (stall_o !== 1'b1 || alu_operator_o !== ALU_MAC) begin
            bad++;
            $display("FAIL %s start: stall=%b op=%0d, required stall=1 op=%0d", nm, stall_o, alu_operator_o, ALU_MAC);
        end
        @(posedge clk_i); #1;
        drive_idle();
        seen = 0; lat = 0;
        for (int unsigned cyc = 1; cyc <= 40 && !seen; cyc++) begin
            mul_valid_i = (cyc == delay);
            if (cyc == delay + 2) begin
                acc_clr_i = clr_done; acc_sel_i = sel;
                if (req_done) begin alu_operator_i = ALU_MAC; mac_en_i = 1'b1; end
            end
            #1;
            if (result_valid_o === 1'b1) begin
                seen = 1; lat = cyc;
            end else begin
                total++;
                if (stall_o !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall cyc%0d: got %b, required 1", nm, cyc, stall_o);
                end
                if (cyc == 1) begin
                    total++;
                    if (alu_operator_o !== ALU_MUL || alu_operand_a_o !== a || alu_operand_b_o !== b) begin
                        bad++;
                        $display("FAIL %s mul_phase: op=%0d a=%h b=%h, required op=%0d a=%h b=%h",
                                 nm, alu_operator_o, alu_operand_a_o, alu_operand_b_o, ALU_MUL, a, b);
                    end
                end
                if (cyc == delay + 1) begin
                    total++;
                    if (alu_operator_o !== (sub ? ALU_SUB : ALU_ADD) ||
                        alu_operand_a_o !== addend || alu_operand_b_o !== prod) begin
                        bad++;
                        $display("FAIL %s add_phase: op=%0d a=%h b=%h, required op=%0d a=%h b=%h", nm,
                                 alu_operator_o, alu_operand_a_o, alu_operand_b_o,
                                 sub ? ALU_SUB : ALU_ADD, addend, prod);
                    end
                end
                @(posedge clk_i); #1;
            end
        end
        got = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no result_valid within 40 cycles, required after %0d", nm, delay + 2);
        end else begin
            if (lat != delay + 2 || stall_o !== 1'b0) begin
                bad++;
                $display("FAIL %s latency: got %0d stall=%b, required %0d stall=0", nm, lat, stall_o, delay + 2);
            end
            total++;
            if (result_o !== got) begin
                bad++;
                $display("FAIL %s result: got %h, required %h", nm, result_o, got);
            end
        end
        last_res = got;
        @(posedge clk_i); #1;
        drive_idle();
        #1;
        total++;
        if (result_valid_o !== 1'b0 || result_o !== got || stall_o !== 1'b0 || alu_operator_o !== ALU_ADD) begin
            bad++;
            $display("FAIL %s after_done: valid=%b res=%h stall=%b op=%0d, required valid=0 res=%h stall=0 op=%0d",
                     nm, result_valid_o, result_o, stall_o, alu_operator_o, got, ALU_ADD);
        end
    endtask

    task automatic read_acc(input string nm, input logic [1:0] sel);
        run_mac(nm, 32'd0, $urandom, $urandom, 1'b1, 1'b0, sel, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive_idle();
        alu_operator_i = ALU_XOR; operand_a_i = 32'hA5A5_0001; operand_b_i = 32'h0F0F_0002;
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        last_res = '0;
        #12;
        total++;
        if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 32'd0 || alu_operator_o !== ALU_XOR ||
            alu_operand_a_o !== 32'hA5A5_0001 || alu_operand_b_o !== 32'h0F0F_0002) begin
            bad++;
            $display("FAIL reset: stall=%b valid=%b res=%h op=%0d a=%h b=%h, required 0 0 0 op=%0d passthrough",
                     stall_o, result_valid_o, result_o, alu_operator_o, alu_operand_a_o, alu_operand_b_o, ALU_XOR);
        end
        #10 rst_ni = 1'b1;
        drive_idle();
    endtask

    task automatic test_basic();
        run_mac("basic_3x4p5", 32'd3, 32'd4, 32'd5, 1'b0, 1'b0, 2'd0, 1, 1'b0, 1'b0);
        total++;
        if (last_res !== 32'd17) begin
            bad++;
            $display("FAIL basic_value: got %0d, required 17", last_res);
        end
    endtask

    task automatic test_acc_sub();
        run_mac("load_acc2", 32'd2, 32'd5, 32'd0, 1'b1, 1'b0, 2'd2, 1, 1'b0, 1'b0);
        run_mac("sub_acc2", 32'd2, 32'd3, 32'd99, 1'b1, 1'b1, 2'd2, 4, 1'b0, 1'b0);
        total++;
        if (last_res !== 32'd4) begin
            bad++;
            $display("FAIL sub_value: got %0d, required 4", last_res);
        end
        read_acc("read_acc2", 2'd2);
    endtask

    task automatic test_patterns();
        for (int n = 0; n < 8; n++) begin
            run_mac("random", $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom_range(1, 3), 1'b0, 1'b0);
        end
        for (int s = 0; s < 4; s++) read_acc("read_rand", 2'(s));
    endtask

    task automatic test_flush();
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk_i); #1;
            alu_operator_i = ALU_MAC; mac_en_i = 1'b1; use_acc_i = 1'b1; acc_sel_i = 2'd1;
            operand_a_i = 32'd7; operand_b_i = 32'd9;
            @(posedge clk_i); #1;
            drive_idle();
            if (ph == 1) begin
                mul_valid_i = 1'b1;
                @(posedge clk_i); #1;
                mul_valid_i = 1'b0;
            end
            flush_i = 1'b1;
            @(posedge clk_i); #1;
            drive_idle();
            alu_operator_i = ALU_XOR; operand_a_i = 32'h1234_5678; operand_b_i = 32'h9ABC_DEF0;
            #1;
            total++;
            if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || alu_operator_o !== ALU_XOR ||
                alu_operand_a_o !== 32'h1234_5678 || alu_operand_b_o !== 32'h9ABC_DEF0 || result_o !== last_res) begin
                bad++;
                $display("FAIL flush_ph%0d: stall=%b valid=%b op=%0d a=%h res=%h, required 0 0 op=%0d a=12345678 res=%h",
                         ph, stall_o, result_valid_o, alu_operator_o, alu_operand_a_o, result_o, ALU_XOR, last_res);
            end
            for (int k = 0; k < 3; k++) begin
                @(posedge clk_i); #1;
                total++;
                if (result_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_strobe: got valid=%b, required 0", result_valid_o);
                end
            end
            drive_idle();
        end
        read_acc("acc1_after_flush", 2'd1);
    endtask

    task automatic test_clear();
        run_mac("load_acc3", 32'd6, 32'd7, 32'd0, 1'b1, 1'b0, 2'd3, 2, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        acc_clr_i = 1'b1; acc_sel_i = 2'd3;
        acc_m[3] = '0;
        @(posedge clk_i); #1;
        drive_idle();
        read_acc("acc3_cleared", 2'd3);
        run_mac("load_acc1", 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 2'd1, 1, 1'b0, 1'b0);
        run_mac("collide_acc1", 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 2'd1, 2, 1'b1, 1'b0);
        read_acc("acc1_clear_wins", 2'd1);
    endtask

    task automatic test_saturate();
        run_mac("pos_edge", 32'd1, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 2'd0, 1, 1'b0, 1'b0);
        total++;
`ifdef CVE2_MAC_SATURATE_EN
        if (last_res !== 32'h7FFF_FFFF) begin
`else
        if (last_res !== 32'h8000_0000) begin
`endif
            bad++;
            $display("FAIL pos_overflow: got %h", last_res);
        end
        run_mac("neg_edge", 32'd1, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 2'd0, 1, 1'b0, 1'b0);
        run_mac("sub_min", 32'h8000_0000, 32'd1, 32'd5, 1'b0, 1'b1, 2'd0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mac("req_in_done_a", 32'd11, 32'd13, 32'd1, 1'b0, 1'b0, 2'd0, 1, 1'b0, 1'b1);
        run_mac("req_in_done_b", 32'd2, 32'd2, 32'd2, 1'b0, 1'b1, 2'd0, 3, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_mul();
        run_mac("load_acc0", 32'd4, 32'd4, 32'd0, 1'b1, 1'b0, 2'd0, 1, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        alu_operator_i = ALU_MAC; mac_en_i = 1'b1; operand_a_i = 32'd9; operand_b_i = 32'd9;
        @(posedge clk_i); #1;
        drive_idle();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        #1;
        total++;
        if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 32'd0 || alu_operator_o !== ALU_ADD) begin
            bad++;
            $display("FAIL reset_mid_mul: stall=%b valid=%b res=%h op=%0d, required 0 0 0 op=%0d",
                     stall_o, result_valid_o, result_o, alu_operator_o, ALU_ADD);
        end
        @(posedge clk_i); #3;
        rst_ni = 1'b1;
        run_mac("after_reset", 32'd3, 32'd4, 32'd5, 1'b0, 1'b0, 2'd0, 1, 1'b0, 1'b0);
        read_acc("acc0_after_reset", 2'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_acc_sub();
        test_patterns();
        test_flush();
        test_clear();
        test_saturate();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cve2_mac_sequencer.md
CVE2_MAC_SEQUENCER -- requirements
Module: cve2_mac_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 32: operand, result and accumulator width.
REQ-002 SHALL have parameter NumAcc, default 4: number of internal accumulators, a power of two, 1 or greater.
REQ-003 SHALL define AccIdxW = max(1, $clog2(NumAcc)).
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 alu_operator_i  in  cve2_pkg::alu_op_e  decoded operator.
REQ-007 mac_en_i  in  1  MAC enable.
REQ-008 mac_sub_i  in  1  0: acc + a*b; 1: acc - a*b.
REQ-009 use_acc_i  in  1  1: addend from accumulator; 0: addend from operand_c_i.
REQ-010 acc_sel_i  in  AccIdxW  accumulator index.
REQ-011 operand_a_i, operand_b_i, operand_c_i  in  DataWidth each  multiplicand, multiplier, external addend.
REQ-012 flush_i  in  1  abort the current operation.
REQ-013 acc_clr_i  in  1  zero accumulator acc_sel_i.
REQ-014 alu_operator_o  out  cve2_pkg::alu_op_e  operator to the ALU.
REQ-015 alu_operand_a_o, alu_operand_b_o  out  DataWidth each  ALU operands.
REQ-016 alu_result_i  in  DataWidth  ALU/multiplier result.
REQ-017 mul_valid_i  in  1  multiplier result valid.
REQ-018 stall_o  out  1  hold the ID stage.
REQ-019 result_o  out  DataWidth  MAC result.
REQ-020 result_valid_o  out  1  one-cycle result strobe.

Function
REQ-021 The FSM SHALL have states IDLE, MUL, ADD and DONE.
REQ-022 IDLE: alu_operator_o SHALL equal alu_operator_i combinationally; operands SHALL pass operand_a_i/operand_b_i; stall_o=0.
REQ-023 Start SHALL occur in IDLE on alu_operator_i==ALU_MAC and mac_en_i=1 and flush_i=0; it SHALL latch a, b, addend, mac_sub_i, use_acc_i and acc_sel_i; next state MUL; stall_o=1 in the start cycle.
REQ-024 The addend SHALL be acc[acc_sel_i] when use_acc_i=1, otherwise operand_c_i, sampled at start.
REQ-025 MUL: operator ALU_MUL, operands latched a,b; stall_o=1; it SHALL remain until mul_valid_i=1, then capture the low DataWidth bits of alu_result_i as the product and go to ADD.
REQ-026 ADD: operator ALU_ADD (or ALU_SUB when mac_sub latched); operand_a = addend, operand_b = product; stall_o=1; it SHALL capture alu_result_i and go to DONE.
REQ-027 DONE: result_valid_o=1 for exactly one cycle; stall_o=0; accumulator write of the result if use_acc latched; next state IDLE.
REQ-028 Latency from start to result_valid_o SHALL be N+2 cycles, where N is the number of MUL cycles, N of 1 or more.
REQ-029 result_o SHALL hold its value until the next DONE.
REQ-030 flush_i in MUL or ADD SHALL return the FSM to IDLE next cycle with no accumulator write and no result_valid_o.
REQ-031 acc_clr_i SHALL zero acc[acc_sel_i] next cycle; on a same-index collision with a DONE write, clear SHALL win.
REQ-032 A MAC request arriving in DONE SHALL be ignored; the ID stage re-presents it in IDLE.
REQ-033 Arithmetic SHALL be two's complement, wrapping modulo 2^DataWidth unless MAC_SATURATE_EN is defined.
REQ-034 Undefined state encodings SHALL recover to IDLE.

Reset
REQ-035 When rst_ni=0: state IDLE, all accumulators 0, result_o 0, result_valid_o 0, stall_o 0, latched operands 0.
REQ-036 Reset during MUL or ADD SHALL discard the operation with no output strobe.

Configuration
REQ-037 With macro CVE2_MAC_SATURATE_EN defined, the ADD result SHALL saturate on signed overflow to 2^(DataWidth-1)-1 or -2^(DataWidth-1).
REQ-038 Overflow SHALL be detected from the operand signs and the alu_result_i sign.
REQ-039 Without CVE2_MAC_SATURATE_EN, the result SHALL wrap and the saturation logic SHALL be absent.

Verification
REQ-040 a=3, b=4, c=5, use_acc=0, mul_valid after 1 cycle -> operator ALU_MUL then ALU_ADD; result 17; result_valid on cycle 3; stall cycles 0-2.
REQ-041 acc[2]=10, a=2, b=3, use_acc=1, mac_sub=1, mul_valid delayed 4 cycles -> result 4; acc[2]=4; latency 6.
REQ-042 flush_i asserted in ADD -> no result_valid; acc unchanged; IDLE passthrough the next cycle.
REQ-043 DONE write to acc[1] while acc_clr_i with acc_sel_i=1 -> acc[1]=0.
REQ-044 With the macro: addend 0x7FFFFFFF plus product 1 -> 0x7FFFFFFF; without it -> 0x80000000.
REQ-045 Reset asserted mid-MUL -> all outputs at reset values; the next MAC starts normally.
